// File: rtl/unit_test_sequencer.sv
// Regression sequencer for the unit-test harness.
// Walks the enabled channels in order, issues indexed vector requests, compares each masked
// DUT response against its golden value and accumulates pass/fail/timeout statistics plus
// the location of the first failure.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 launch a run (honoured only in IDLE or DONE)
//   chan_mask_i, num_vec_i  run configuration, latched at start (num_vec clamped to VECTORS)
//   vec_req_o               one-cycle request for vector (vec_chan_o, vec_idx_o)
//   dut_valid_i             response strobe, sampled only while waiting
//   dut_actual_i, dut_expected_i, cmp_mask_i   response, golden value, compare mask
//   busy_o, done_o          run in progress / run finished (level until next start)
//   pass_cnt_o, fail_cnt_o, timeout_cnt_o      saturating statistics
//   ff_valid_o, ff_chan_o, ff_idx_o            first-failure capture
module unit_test_sequencer #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned VECTORS  = 16,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned IW = (VECTORS > 1) ? $clog2(VECTORS) : 1,
  localparam int unsigned VW = $clog2(VECTORS + 1),
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [CHANNELS-1:0] chan_mask_i,
  input  logic [VW-1:0]       num_vec_i,
  output logic                vec_req_o,
  output logic [CW-1:0]       vec_chan_o,
  output logic [IW-1:0]       vec_idx_o,
  input  logic                dut_valid_i,
  input  logic [WIDTH-1:0]    dut_actual_i,
  input  logic [WIDTH-1:0]    dut_expected_i,
  input  logic [WIDTH-1:0]    cmp_mask_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    pass_cnt_o,
  output logic [CNT_W-1:0]    fail_cnt_o,
  output logic [CNT_W-1:0]    timeout_cnt_o,
  output logic                ff_valid_o,
  output logic [CW-1:0]       ff_chan_o,
  output logic [IW-1:0]       ff_idx_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_NEXT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [VW-1:0]       nvec_q, nvec_d;
  logic [CNT_W-1:0]    pass_q, pass_d;
  logic [CNT_W-1:0]    fail_q, fail_d;
  logic [CNT_W-1:0]    tout_q, tout_d;
  logic                ff_valid_q, ff_valid_d;
  logic [CW-1:0]       ff_chan_q, ff_chan_d;
  logic [IW-1:0]       ff_idx_q, ff_idx_d;

  logic rec_pass, rec_fail, rec_tout;
  logic last_chan, last_idx, resp_ok;

  assign last_chan = (chan_q == CW'(CHANNELS - 1));
  // Only evaluated in NEXT, where nvec_q is known to be non-zero.
  assign last_idx  = (VW'(idx_q) == (nvec_q - VW'(1)));
  assign resp_ok   = (((dut_actual_i ^ dut_expected_i) & cmp_mask_i) == '0);

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    mask_d     = mask_q;
    nvec_d     = nvec_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tout_d     = tout_q;
    ff_valid_d = ff_valid_q;
    ff_chan_d  = ff_chan_q;
    ff_idx_d   = ff_idx_q;
    rec_pass   = 1'b0;
    rec_fail   = 1'b0;
    rec_tout   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          mask_d     = chan_mask_i;
          nvec_d     = (num_vec_i > VW'(VECTORS)) ? VW'(VECTORS) : num_vec_i;
          pass_d     = '0;
          fail_d     = '0;
          tout_d     = '0;
          ff_valid_d = 1'b0;
          ff_chan_d  = '0;
          ff_idx_d   = '0;
          chan_d     = '0;
          idx_d      = '0;
          timer_d    = '0;
          state_d    = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (mask_q[chan_q] && (nvec_q != '0)) begin
          state_d = ST_ISSUE;
        end else if (last_chan) begin
          state_d = ST_DONE;
        end else begin
          chan_d = chan_q + CW'(1);
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dut_valid_i) begin
          rec_pass = resp_ok;
          rec_fail = ~resp_ok;
          state_d  = ST_NEXT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          // Timer counts WAIT cycles 0..TIMEOUT-1, so a timeout costs exactly TIMEOUT cycles.
          rec_fail = 1'b1;
          rec_tout = 1'b1;
          state_d  = ST_NEXT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_NEXT: begin
        if (last_idx) begin
          idx_d = '0;
          if (last_chan) begin
            state_d = ST_DONE;
          end else begin
            chan_d  = chan_q + CW'(1);
            state_d = ST_SELECT;
          end
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Statistics saturate rather than wrap.
    if (rec_pass && (pass_q != '1)) pass_d = pass_q + CNT_W'(1);
    if (rec_fail && (fail_q != '1)) fail_d = fail_q + CNT_W'(1);
    if (rec_tout && (tout_q != '1)) tout_d = tout_q + CNT_W'(1);
    if (rec_fail && !ff_valid_q) begin
      ff_valid_d = 1'b1;
      ff_chan_d  = chan_q;
      ff_idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      chan_q     <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      mask_q     <= '0;
      nvec_q     <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      tout_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_chan_q  <= '0;
      ff_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      mask_q     <= mask_d;
      nvec_q     <= nvec_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tout_q     <= tout_d;
      ff_valid_q <= ff_valid_d;
      ff_chan_q  <= ff_chan_d;
      ff_idx_q   <= ff_idx_d;
    end
  end

  assign vec_req_o     = (state_q == ST_ISSUE);
  assign vec_chan_o    = chan_q;
  assign vec_idx_o     = idx_q;
  assign busy_o        = (state_q == ST_SELECT) || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT) || (state_q == ST_NEXT);
  assign done_o        = (state_q == ST_DONE);
  assign pass_cnt_o    = pass_q;
  assign fail_cnt_o    = fail_q;
  assign timeout_cnt_o = tout_q;
  assign ff_valid_o    = ff_valid_q;
  assign ff_chan_o     = ff_chan_q;
  assign ff_idx_o      = ff_idx_q;

endmodule

// File: tb/tb_unit_test_sequencer.sv
// Randomised bench for unit_test_sequencer with a transaction-level reference model:
// expected request order, per-vector outcome, saturating totals, first failure and the
// start-to-done cycle count are all derived from the run configuration and the responses
// the bench chooses to give.
module tb_unit_test_sequencer;
  localparam int unsigned WIDTH    = 32;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned VECTORS  = 16;
  localparam int unsigned TIMEOUT  = 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned SAT      = (1 << CNT_W) - 1;

  localparam int MODE_RAND   = 0;
  localparam int MODE_ECHO   = 1;
  localparam int MODE_FF     = 2;
  localparam int MODE_FF_MSK = 3;
  localparam int MODE_SILENT = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [3:0]       chan_mask_i;
  logic [4:0]       num_vec_i;
  logic             vec_req_o;
  logic [1:0]       vec_chan_o;
  logic [3:0]       vec_idx_o;
  logic             dut_valid_i;
  logic [WIDTH-1:0] dut_actual_i, dut_expected_i, cmp_mask_i;
  logic             busy_o, done_o;
  logic [CNT_W-1:0] pass_cnt_o, fail_cnt_o, timeout_cnt_o;
  logic             ff_valid_o;
  logic [1:0]       ff_chan_o;
  logic [3:0]       ff_idx_o;

  unit_test_sequencer #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .VECTORS(VECTORS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .chan_mask_i(chan_mask_i),
    .num_vec_i(num_vec_i), .vec_req_o(vec_req_o), .vec_chan_o(vec_chan_o),
    .vec_idx_o(vec_idx_o), .dut_valid_i(dut_valid_i), .dut_actual_i(dut_actual_i),
    .dut_expected_i(dut_expected_i), .cmp_mask_i(cmp_mask_i), .busy_o(busy_o),
    .done_o(done_o), .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o),
    .timeout_cnt_o(timeout_cnt_o), .ff_valid_o(ff_valid_o), .ff_chan_o(ff_chan_o),
    .ff_idx_o(ff_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > int'(SAT)) ? int'(SAT) : v;
  endfunction

  task automatic idle_inputs();
    start_i        = 1'b0;
    dut_valid_i    = 1'b0;
    dut_actual_i   = $urandom;
    dut_expected_i = $urandom;
    cmp_mask_i     = $urandom;
  endtask

  // One complete run: start, respond to every request, compare totals at done.
  task automatic run_seq(input logic [3:0] mask, input int nvec, input int mode,
                         input bit poke_start, input string name);
    int exp_q[$];
    int n_eff, e_pass, e_fail, e_tout, e_ffc, e_ffi, e_cycles, cycles, j, cur_d, c, i, tag;
    bit e_ff, active, seen_done, fail_now;
    logic [31:0] cur_exp, cur_flip, cur_cmp, cur_addr;
    n_eff = (nvec > int'(VECTORS)) ? int'(VECTORS) : nvec;
    for (int ch = 0; ch < int'(CHANNELS); ch++)
      if (mask[ch]) for (int k = 0; k < n_eff; k++) exp_q.push_back(ch * 16 + k);
    e_pass = 0; e_fail = 0; e_tout = 0; e_ff = 0; e_ffc = 0; e_ffi = 0;
    e_cycles = int'(CHANNELS) + 1;
    cycles = 0; j = 0; cur_d = 0; active = 0; seen_done = 0;
    cur_exp = '0; cur_flip = '0; cur_cmp = '0; cur_addr = '0;

    @(negedge clk_i);
    idle_inputs();
    start_i     = 1'b1;
    chan_mask_i = mask;
    num_vec_i   = 5'(nvec);
    while (cycles < 4000) begin
      @(negedge clk_i);
      cycles++;
      idle_inputs();
      // Configuration must already be latched.
      chan_mask_i = 4'($urandom);
      num_vec_i   = 5'($urandom);
      if (done_o) begin
        seen_done = 1;
        break;
      end
      check_eq({name, " busy"}, busy_o, 1);
      if (poke_start && ($urandom_range(0, 3) == 0)) start_i = 1'b1;
      if (vec_req_o) begin
        if (exp_q.size() == 0) begin
          check_eq({name, " extra_req"}, vec_req_o, 0);
          active = 0;
        end else begin
          tag = exp_q.pop_front();
          c = tag / 16;
          i = tag % 16;
          cur_addr = 32'(tag);
          check_eq({name, " req_addr"}, {vec_chan_o, vec_idx_o}, cur_addr);
          cur_exp = $urandom;
          case (mode)
            MODE_ECHO:   begin cur_d = 1; cur_flip = '0; cur_cmp = '1; end
            MODE_FF:     begin cur_d = 0; cur_flip = (i == 2) ? 1 : 0; cur_cmp = '1; end
            MODE_FF_MSK: begin cur_d = 0; cur_flip = (i == 2) ? 1 : 0; cur_cmp = 32'hFFFF_FFFE; end
            MODE_SILENT: begin cur_d = TIMEOUT; cur_flip = '0; cur_cmp = '1; end
            default: begin
              cur_d    = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
              cur_flip = ($urandom_range(0, 2) == 0) ? $urandom : 0;
              cur_cmp  = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
          endcase
          if (cur_d >= int'(TIMEOUT)) begin
            fail_now = 1;
            e_tout++;
            e_cycles += 2 + int'(TIMEOUT);
          end else begin
            fail_now = ((cur_flip & cur_cmp) != 0);
            e_cycles += 2 + cur_d + 1;
          end
          if (fail_now) e_fail++; else e_pass++;
          if (fail_now && !e_ff) begin
            e_ff = 1; e_ffc = c; e_ffi = i;
          end
          active = 1;
          j = 0;
        end
      end else if (active) begin
        if (j == cur_d) begin
          dut_valid_i    = 1'b1;
          dut_expected_i = cur_exp;
          dut_actual_i   = cur_exp ^ cur_flip;
          cmp_mask_i     = cur_cmp;
          check_eq({name, " addr_hold"}, {vec_chan_o, vec_idx_o}, cur_addr);
          active = 0;
        end else begin
          j++;
          if (j >= int'(TIMEOUT)) active = 0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // Stray mismatching response outside WAIT must be ignored.
        dut_valid_i  = 1'b1;
        dut_actual_i = ~dut_expected_i;
        cmp_mask_i   = '1;
      end
    end
    start_i = 1'b0;
    check_eq({name, " done_seen"}, seen_done, 1);
    check_eq({name, " latency"}, cycles, e_cycles);
    check_eq({name, " reqs_left"}, exp_q.size(), 0);
    check_eq({name, " pass_cnt"}, pass_cnt_o, sat(e_pass));
    check_eq({name, " fail_cnt"}, fail_cnt_o, sat(e_fail));
    check_eq({name, " tout_cnt"}, timeout_cnt_o, sat(e_tout));
    check_eq({name, " ff"}, {ff_valid_o, ff_chan_o, ff_idx_o}, {e_ff, 2'(e_ffc), 4'(e_ffi)});
    check_eq({name, " busy_done"}, busy_o, 0);
    repeat (2) @(negedge clk_i);
    check_eq({name, " done_hold"}, done_o, 1);
  endtask

  task automatic check_cleared(input string name);
    check_eq({name, " flags"}, {busy_o, done_o, vec_req_o, ff_valid_o}, 0);
    check_eq({name, " cnts"}, {pass_cnt_o, fail_cnt_o, timeout_cnt_o}, 0);
    check_eq({name, " addr"}, {vec_chan_o, vec_idx_o, ff_chan_o, ff_idx_o}, 0);
  endtask

  // Reset in the middle of WAIT for (chan 1, idx 1).
  task automatic reset_mid_run();
    bit found;
    found = 0;
    @(negedge clk_i);
    idle_inputs();
    start_i = 1'b1; chan_mask_i = 4'b0011; num_vec_i = 5'd2;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (vec_req_o && vec_chan_o == 2'd1 && vec_idx_o == 4'd1) begin
        found = 1;
        break;
      end
    end
    check_eq("rst_reach", found, 1);
    @(negedge clk_i);
    check_eq("rst_pre_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    check_cleared("rst_mid");
    @(posedge clk_i);
    #1;
    check_cleared("rst_edge");
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    chan_mask_i = '0;
    num_vec_i = '0;
    idle_inputs();
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_cleared("idle");

    run_seq(4'b0101, 3, MODE_ECHO, 0, "echo");
    run_seq(4'b0001, 4, MODE_FF, 0, "ff");
    run_seq(4'b0001, 4, MODE_FF_MSK, 0, "ff_msk");
    run_seq(4'b0010, 2, MODE_SILENT, 0, "tout");
    run_seq(4'b0000, 5, MODE_ECHO, 1, "nomask");
    run_seq(4'b1111, 0, MODE_ECHO, 1, "novec");
    run_seq(4'b1000, 31, MODE_ECHO, 1, "clamp");
    reset_mid_run();
    run_seq(4'b0110, 2, MODE_RAND, 0, "post_rst");
    run_seq(4'b1111, 16, MODE_RAND, 1, "sat");
    for (int r = 0; r < 16; r++)
      run_seq(4'($urandom), $urandom_range(0, 20), MODE_RAND, 1, "rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/unit_test_sequencer.md
Name: unit_test_sequencer

Overview:
- Synthesizable, self-checking regression sequencer for the unit-test harness.
- Walks up to CHANNELS unit-under-test channels in turn and issues indexed vector requests to each.
- Compares each masked DUT response against its expected value and accumulates pass, fail and timeout statistics plus first-failure capture.
- Generalises the fixed, simulation-only harness into a parametrised, channel-maskable, hardware-resident sequencer.

Parameters:
- WIDTH, 32, data width of actual, expected and compare mask.
- CHANNELS, 4, number of test channels; CW = max(1,$clog2(CHANNELS)).
- VECTORS, 16, maximum vectors per channel; IW = max(1,$clog2(VECTORS)), VW = $clog2(VECTORS+1).
- TIMEOUT, 64, cycles to wait for dut_valid before declaring a timeout fail; must be >= 1.
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launches a run; sampled in IDLE or DONE only.
- chan_mask  in  CHANNELS  bit c=1 enables channel c; sampled at start.
- num_vec  in  VW  vectors per enabled channel, shared by all channels; sampled at start; values above VECTORS are clamped to VECTORS.
- vec_req  out  1  one-cycle request to apply vector (vec_chan, vec_idx).
- vec_chan  out  CW  channel being exercised.
- vec_idx  out  IW  vector index within the channel.
- dut_valid  in  1  DUT response valid; sampled in WAIT only.
- dut_actual  in  WIDTH  DUT response.
- dut_expected  in  WIDTH  golden response.
- cmp_mask  in  WIDTH  bits participating in the compare.
- busy  out  1  high in SELECT, ISSUE, WAIT and NEXT.
- done  out  1  level; high in DONE until the next start.
- pass_cnt  out  CNT_W  passing vectors.
- fail_cnt  out  CNT_W  failing vectors, including timeouts.
- timeout_cnt  out  CNT_W  vectors that timed out.
- ff_valid  out  1  a first failure has been captured.
- ff_chan  out  CW  channel of the first failure.
- ff_idx  out  IW  index of the first failure.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, chan = idx = 0, timer = 0.
- States: IDLE, SELECT, ISSUE, WAIT, NEXT, DONE.
- IDLE/DONE + start: latch chan_mask and clamped num_vec; clear counters, ff_* and done; chan = 0, idx = 0; go to SELECT.
- IDLE/DONE + no start: hold state.
- SELECT: one channel examined per cycle.
  - mask[chan] = 1 and num_vec != 0 → ISSUE.
  - Else, if chan == CHANNELS-1 → DONE.
  - Else chan++ and stay in SELECT.
- ISSUE: vec_req = 1 for exactly this cycle; timer = 0; → WAIT.
- WAIT:
  - dut_valid = 1: pass iff ((dut_actual ^ dut_expected) & cmp_mask) == 0. On pass, pass_cnt++; on fail, fail_cnt++. → NEXT.
  - dut_valid = 0: timer++. When the timer reaches TIMEOUT-1, fail_cnt++, timeout_cnt++, → NEXT. Minimum wait is TIMEOUT cycles.
- Any fail with ff_valid = 0: ff_valid = 1, ff_chan = chan, ff_idx = idx. Later fails do not update ff_*.
- NEXT:
  - idx == num_vec-1 → idx = 0, then DONE if chan == CHANNELS-1, else chan++ and SELECT.
  - Else idx++ and → ISSUE.
- Latency per vector: ISSUE + WAIT (>= 1 cycle) + NEXT, so at least 3 cycles when dut_valid is high on the first WAIT cycle.
- dut_valid outside WAIT is ignored. start while busy is ignored.
- Counters saturate at 2^CNT_W-1.
- chan_mask = 0 or num_vec = 0: SELECT scans all channels and reaches DONE with zero counts. Latency is CHANNELS+1 cycles from start to done.
- Reset asserted mid-run: immediate return to IDLE, all outputs cleared, no partial results retained.
- vec_chan and vec_idx stay stable from ISSUE through NEXT.

Test Plan:
1. CHANNELS=4, mask=4'b0101, num_vec=3, DUT echoes expected after 2 cycles → 6 vec_req pulses on (chan,idx) = (0,0),(0,1),(0,2),(2,0),(2,1),(2,2); pass_cnt=6, fail_cnt=0, done=1, ff_valid=0.
2. mask=4'b0001, num_vec=4, actual=expected^32'h1 on idx 2, cmp_mask=32'hFFFFFFFF → pass_cnt=3, fail_cnt=1, ff_valid=1, ff_chan=0, ff_idx=2.
3. Same as scenario 2 but cmp_mask=32'hFFFFFFFE → pass_cnt=4, fail_cnt=0, ff_valid=0.
4. TIMEOUT=8, dut_valid never asserted, mask=4'b0010, num_vec=2 → timeout_cnt=2, fail_cnt=2, ff_chan=1, ff_idx=0; each WAIT lasts exactly 8 cycles.
5. mask=4'b0000 → done asserted CHANNELS+1 cycles after start; no vec_req pulses; all counters 0. start pulsed while busy in another run → ignored.
6. reset asserted during WAIT of chan 1, idx 1 → next edge shows busy=0, done=0, all counters and ff_* = 0. A subsequent start runs cleanly from (0,0).
